alu_mem_unit: RTL and testbench
===============================

Name: alu_mem_unit

Overview:
- Execute/memory slice of the single-cycle datapath: decodes ALUOp and funct into a 4-bit ALU control, computes a 32-bit result and zero flag, and reads/writes a word-indexed data memory.
- The ALU result is the memory address; `write_data` comes from the register file's second read port.
- It sits between the register file / sign-extend mux and the writeback mux.

Parameters:
- DATA_W, 32, operand/result/memory word width
- DEPTH, 32, number of data memory words (power of two)
- ADDR_W, 5, log2(DEPTH); memory index width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- alu_op  in  2  from control unit: 00 add, 01 sub, 10 R-type (use funct), 11 or
- funct  in  6  instruction bits [5:0]
- operand_a  in  DATA_W  register-file read A
- operand_b  in  DATA_W  ALUSrc mux output (register B or sign-extended immediate)
- mem_read  in  1  enables `read_data` output
- mem_write  in  1  write strobe
- write_data  in  DATA_W  store data (register B)
- alu_ctrl  out  4  decoded ALU control
- alu_result  out  DATA_W  ALU result, also memory address
- zero  out  1  1 when `alu_result` == 0
- read_data  out  DATA_W  memory read data

Behaviour:
- One clock domain. `reset`=0 asynchronously clears every memory word to 0; no other state exists.
- `alu_ctrl`, `alu_result`, `zero` and `read_data` are purely combinational (zero latency). Their values during reset follow the inputs; `read_data` reads 0 during reset.
- ALU control decode:
  - alu_op=00 -> 0010 (add); alu_op=01 -> 0110 (sub); alu_op=11 -> 0001 (or).
  - alu_op=10 decodes funct: 000000 add (0010), 000010 sub (0110), 000100 and (0000), 000101 or (0001), 000110 xor (0011), 000111 nor (1100), 001010 slt (0111). Any other funct -> add (0010).
- ALU operations:
  - 0000 a&b; 0001 a|b; 0011 a^b; 1100 ~(a|b).
  - 0010 a+b; 0110 a-b.
  - 0111: 1 if signed(a)<signed(b), else 0.
  - Any undefined control -> 0.
- Arithmetic wraps modulo 2^32; no overflow flag or trap.
- `zero` is derived from `alu_result` for every operation. Branch-equal uses sub, so `zero`=1 iff a==b.
- Memory index = `alu_result[ADDR_W-1:0]` (word index, not byte address); upper bits ignored, so addresses alias modulo DEPTH.
- Write: on rising clk with `mem_write`=1 and reset deasserted, mem[index] <= `write_data`.
- Read: `read_data` = mem[index] when `mem_read`=1, else 0.
- Simultaneous `mem_read` and `mem_write` to the same index: before the edge `read_data` shows the old word; after the edge it shows the new word. No bypass.
- Reset asserted mid-cycle: memory clears immediately. A write edge while `reset`=0 is ignored.

Decomposition:
- Shared package `alu_mem_pkg`:
  - ALU control codes: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_NOR.
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_OR.
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT.
- One sub-module, `alu_mem_ram`: DEPTH x DATA_W array with async clear, sync write, combinational gated read.
- Control decode and ALU stay inline in the top.

Test Plan:
- Reset: hold `reset`=0, then release; `mem_read`=1 at indices 0, 5, 31 -> `read_data`=0.
- I-type add: alu_op=00, a=0, b=5 -> `alu_ctrl`=0010, `alu_result`=5, `zero`=0.
- Store then load:
  - Cycle 1: alu_op=00, a=0, b=5, mem_write=1, write_data=5; clock edge.
  - Then mem_write=0, mem_read=1 with the same address -> `read_data`=5.
  - mem_read=0 -> `read_data`=0.
- R-type:
  - alu_op=10, funct=000000, a=5, b=5 -> result 10.
  - funct=000010, a=5, b=10 -> result 0xFFFFFFFB, `zero`=0.
  - funct=001010, a=0xFFFFFFFF, b=1 -> result 1.
- Branch compare / wrap:
  - alu_op=01, a=b=0x1234 -> `zero`=1.
  - alu_op=00, a=0xFFFFFFFF, b=1 -> result 0, `zero`=1.
- Aliasing:
  - Write 0xA5A5A5A5 at address 37 -> readable at address 5.
  - Assert `reset` asynchronously between edges -> `read_data` drops to 0 without a clock edge.

Source files
------------

// File: rtl/alu_mem_pkg.sv
// Shared encodings for the execute/memory slice: ALUOp codes, funct fields and ALU control codes.
// No logic lives here; every consumer imports alu_mem_pkg::*.
package alu_mem_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000010;
  localparam logic [5:0] F_AND = 6'b000100;
  localparam logic [5:0] F_OR  = 6'b000101;
  localparam logic [5:0] F_XOR = 6'b000110;
  localparam logic [5:0] F_NOR = 6'b000111;
  localparam logic [5:0] F_SLT = 6'b001010;

endpackage

// File: rtl/alu_mem_ram.sv
// Word-indexed data memory: async clear on reset, write on rising clk, combinational read gated by re_i.
// Zero read latency; reads show the pre-edge word when a write to the same index is pending.
module alu_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = re_i ? mem_q[addr_i] : '0;

endmodule

// File: rtl/alu_mem_unit.sv
// Execute/memory slice: ALU control decode, 32-bit ALU with zero flag, and data memory addressed by the result.
// Fully combinational outputs (zero latency); memory writes commit on the rising clk edge.
module alu_mem_unit
  import alu_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] write_data,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [DATA_W-1:0] read_data
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_OR:  alu_ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        // Unrecognised funct values fall back to add.
        case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_XOR:   alu_ctrl = ALU_XOR;
          F_NOR:   alu_ctrl = ALU_NOR;
          F_SLT:   alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = operand_a & operand_b;
      ALU_OR:  alu_result = operand_a | operand_b;
      ALU_XOR: alu_result = operand_a ^ operand_b;
      ALU_NOR: alu_result = ~(operand_a | operand_b);
      ALU_ADD: alu_result = operand_a + operand_b;
      ALU_SUB: alu_result = operand_a - operand_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Upper result bits are dropped, so addresses alias modulo DEPTH.
  alu_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_n_i (reset),
    .we_i    (mem_write),
    .re_i    (mem_read),
    .addr_i  (alu_result[ADDR_W-1:0]),
    .wdata_i (write_data),
    .rdata_o (read_data)
  );

endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed-vector bench for alu_mem_unit: the driver queues hand-computed expectations,
// a negedge monitor pops one per cycle and compares all four outputs.
module tb_alu_mem_unit;
  import alu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b, write_data;
  logic        mem_read, mem_write;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result, read_data;
  logic        zero;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zr;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_mem_unit #(.DATA_W(32), .DEPTH(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .funct      (funct),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_data (write_data),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge; a mid-cycle reset assertion lands 1ns later, still before negedge.
  task automatic apply(input string name, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic mr, input logic mw, input logic [31:0] wd,
                       input logic rst_mid,
                       input logic [3:0] e_ctrl, input logic [31:0] e_res,
                       input logic e_zero, input logic [31:0] e_rd);
    exp_t e;
    @(posedge clk);
    #1;
    alu_op = op; funct = fn; operand_a = a; operand_b = b;
    mem_read = mr; mem_write = mw; write_data = wd;
    e.name = name; e.ctrl = e_ctrl; e.res = e_res; e.zr = e_zero; e.rd = e_rd;
    exp_q.push_back(e);
    if (rst_mid) begin
      #1;
      reset = 1'b0;
    end
  endtask

  task automatic check32(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check32(e.name, "alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
      check32(e.name, "alu_result", alu_result, e.res);
      check32(e.name, "zero", {31'd0, zero}, {31'd0, e.zr});
      check32(e.name, "read_data", read_data, e.rd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    alu_op = 2'b00; funct = 6'd0; operand_a = '0; operand_b = '0;
    mem_read = 1'b0; mem_write = 1'b0; write_data = '0;

    // Reset held: combinational ALU follows inputs, memory reads 0.
    apply("in_reset",   2'b00, 6'd0, 32'd0, 32'd5, 1, 0, 32'd0, 0, 4'b0010, 32'd5, 0, 32'd0);
    @(posedge clk); #1; reset = 1'b1;

    apply("rd_idx0",    2'b00, 6'd0, 32'd0, 32'd0,  1, 0, 32'd0, 0, 4'b0010, 32'd0,  1, 32'd0);
    apply("rd_idx5",    2'b00, 6'd0, 32'd0, 32'd5,  1, 0, 32'd0, 0, 4'b0010, 32'd5,  0, 32'd0);
    apply("rd_idx31",   2'b00, 6'd0, 32'd0, 32'd31, 1, 0, 32'd0, 0, 4'b0010, 32'd31, 0, 32'd0);

    // Store 5 at index 5, then load it back, then gate the read off.
    apply("store",      2'b00, 6'd0, 32'd0, 32'd5, 0, 1, 32'd5, 0, 4'b0010, 32'd5, 0, 32'd0);
    apply("load",       2'b00, 6'd0, 32'd0, 32'd5, 1, 0, 32'd0, 0, 4'b0010, 32'd5, 0, 32'd5);
    apply("rd_off",     2'b00, 6'd0, 32'd0, 32'd5, 0, 0, 32'd0, 0, 4'b0010, 32'd5, 0, 32'd0);

    apply("r_add",      2'b10, 6'b000000, 32'd5, 32'd5,  0, 0, 0, 0, 4'b0010, 32'd10, 0, 32'd0);
    apply("r_sub_neg",  2'b10, 6'b000010, 32'd5, 32'd10, 0, 0, 0, 0, 4'b0110, 32'hFFFF_FFFB, 0, 32'd0);
    apply("r_slt_neg",  2'b10, 6'b001010, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 4'b0111, 32'd1, 0, 32'd0);
    apply("r_slt_pos",  2'b10, 6'b001010, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'b0111, 32'd0, 1, 32'd0);
    apply("r_and",      2'b10, 6'b000100, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 0, 4'b0000, 32'h0000_F000, 0, 32'd0);
    apply("r_or",       2'b10, 6'b000101, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 0, 4'b0001, 32'h0000_FFF0, 0, 32'd0);
    apply("r_xor",      2'b10, 6'b000110, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 0, 4'b0011, 32'h0000_0FF0, 0, 32'd0);
    apply("r_nor",      2'b10, 6'b000111, 32'd0, 32'd0, 0, 0, 0, 0, 4'b1100, 32'hFFFF_FFFF, 0, 32'd0);
    apply("r_unknown",  2'b10, 6'b111111, 32'd1, 32'd2, 0, 0, 0, 0, 4'b0010, 32'd3, 0, 32'd0);

    apply("beq_equal",  2'b01, 6'b111111, 32'h1234, 32'h1234, 0, 0, 0, 0, 4'b0110, 32'd0, 1, 32'd0);
    apply("op_or",      2'b11, 6'd0, 32'h10, 32'h01, 0, 0, 0, 0, 4'b0001, 32'h11, 0, 32'd0);
    apply("add_wrap",   2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 4'b0010, 32'd0, 1, 32'd0);

    // Address 37 aliases index 5; before the edge the old word (5) is still visible.
    apply("alias_wr",   2'b00, 6'd0, 32'd32, 32'd5, 1, 1, 32'hA5A5_A5A5, 0, 4'b0010, 32'd37, 0, 32'd5);
    apply("alias_rd",   2'b00, 6'd0, 32'd0,  32'd5, 1, 0, 32'd0, 0, 4'b0010, 32'd5, 0, 32'hA5A5_A5A5);

    // Reset asserted mid-cycle clears memory with no edge; a write edge under reset is dropped.
    apply("async_rst",  2'b00, 6'd0, 32'd0, 32'd5, 1, 0, 32'd0, 1, 4'b0010, 32'd5, 0, 32'd0);
    apply("wr_in_rst",  2'b00, 6'd0, 32'd0, 32'd5, 1, 1, 32'h0000_DEAD, 0, 4'b0010, 32'd5, 0, 32'd0);
    @(posedge clk); #1; reset = 1'b1; mem_write = 1'b0;
    apply("post_rst",   2'b00, 6'd0, 32'd0, 32'd5, 1, 0, 32'd0, 0, 4'b0010, 32'd5, 0, 32'd0);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
